// File: rtl/fan_countdown_timer.sv
// rtl/fan_countdown_timer.sv - fan off-timer: preset select and BCD MM:SS countdown
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   btn_pe       debounced timer-button rising-edge pulse (1 clk)
//   run_en       fan running; countdown advances only while high
//   value_timer  BCD {min_tens, min_ones, sec_tens, sec_ones}
//   timeout      1-clk pulse when the count expires at 00:00
//   timer_led    one-hot preset indicator, 000 when idle
module fan_countdown_timer #(
  parameter int TICK_DIV    = 125_000_000,
  parameter int PRESET1_MIN = 1,
  parameter int PRESET2_MIN = 3,
  parameter int PRESET3_MIN = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_pe,
  input  logic        run_en,
  output logic [15:0] value_timer,
  output logic        timeout,
  output logic [2:0]  timer_led
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  function automatic logic [7:0] to_bcd(input int m);
    return {4'(m / 10), 4'(m % 10)};
  endfunction

  localparam logic [7:0] P1_BCD = to_bcd(PRESET1_MIN);
  localparam logic [7:0] P2_BCD = to_bcd(PRESET2_MIN);
  localparam logic [7:0] P3_BCD = to_bcd(PRESET3_MIN);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state;
  logic [1:0]    p;
  logic [PW-1:0] presc;
  logic [1:0]    p_nxt;

  assign p_nxt = p + 2'd1;

  function automatic logic [7:0] preset_bcd(input logic [1:0] idx);
    case (idx)
      2'd1:    return P1_BCD;
      2'd2:    return P2_BCD;
      2'd3:    return P3_BCD;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [2:0] led_of(input logic [1:0] idx);
    case (idx)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // One-second BCD decrement with borrows; caller guarantees v != 0000.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      p           <= 2'd0;
      presc       <= '0;
      value_timer <= 16'h0000;
      timeout     <= 1'b0;
      timer_led   <= 3'b000;
    end else begin
      timeout <= 1'b0;
      if (btn_pe) begin
        // Button has priority over any tick in the same cycle, expiring or not.
        p     <= p_nxt;
        presc <= '0;
        if (p_nxt == 2'd0) begin
          state       <= IDLE;
          value_timer <= 16'h0000;
          timer_led   <= 3'b000;
        end else begin
          state       <= run_en ? RUN : PAUSE;
          value_timer <= {preset_bcd(p_nxt), 8'h00};
          timer_led   <= led_of(p_nxt);
        end
      end else if (state != IDLE) begin
        // Counting follows run_en directly so a PAUSE->RUN resume loses no cycle.
        state <= run_en ? RUN : PAUSE;
        if (run_en) begin
          if (presc == PRE_LAST) begin
            presc <= '0;
            if (value_timer == 16'h0001) begin
              value_timer <= 16'h0000;
              timeout     <= 1'b1;
              p           <= 2'd0;
              timer_led   <= 3'b000;
              state       <= IDLE;
            end else begin
              value_timer <= bcd_dec(value_timer);
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
      end
    end
  end

endmodule
